// File: rtl/karatsuba_seq_mul.sv
// Sequential single-level Karatsuba multiplier: z0, z1 and z2 are issued on one shared, pipelined sub-multiplier.
// Optional signed operation is enabled by defining KARATSUBA_SIGNED_EN, which adds the signed_mode input.
module karatsuba_seq_mul #(
  parameter int W       = 64,
  parameter int MUL_LAT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
`ifdef KARATSUBA_SIGNED_EN
  input  logic           signed_mode,
`endif
  output logic           busy,
  output logic [2*W-1:0] p,
  output logic           valid_out
);

  localparam int H   = W / 2;
  localparam int PW  = 2 * H + 2;
  localparam int PW2 = 2 * W;

  typedef enum logic [2:0] {IDLE, ISSUE0, ISSUE1, ISSUE2, WAIT, COMBINE} state_t;

  localparam logic [1:0] TAG_Z0 = 2'd0;
  localparam logic [1:0] TAG_Z1 = 2'd1;
  localparam logic [1:0] TAG_Z2 = 2'd2;

  state_t         state_reg;
  logic [W-1:0]   a_reg, b_reg;
  logic           neg_reg;
  logic [PW-1:0]  z0_reg, z1_reg;

  logic [W-1:0]   a_mag, b_mag;
  logic           neg_in;

`ifdef KARATSUBA_SIGNED_EN
  // Magnitude of -2^(W-1) is 2^(W-1), which still fits in W unsigned bits.
  assign a_mag  = (signed_mode && a[W-1]) ? (~a + W'(1)) : a;
  assign b_mag  = (signed_mode && b[W-1]) ? (~b + W'(1)) : b;
  assign neg_in = signed_mode & (a[W-1] ^ b[W-1]);
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign neg_in = 1'b0;
`endif

  // Issue mux in front of the shared multiplier
  logic          issue_vld;
  logic [1:0]    issue_tag;
  logic [H:0]    mul_x, mul_y;
  logic [H:0]    sa, sb;
  logic [PW-1:0] mul_prod;

  assign sa = {1'b0, a_reg[W-1:H]} + {1'b0, a_reg[H-1:0]};
  assign sb = {1'b0, b_reg[W-1:H]} + {1'b0, b_reg[H-1:0]};

  always_comb begin
    issue_vld = 1'b0;
    issue_tag = TAG_Z0;
    mul_x     = '0;
    mul_y     = '0;
    case (state_reg)
      ISSUE0: begin
        issue_vld = 1'b1;
        issue_tag = TAG_Z0;
        mul_x     = {1'b0, a_reg[H-1:0]};
        mul_y     = {1'b0, b_reg[H-1:0]};
      end
      ISSUE1: begin
        issue_vld = 1'b1;
        issue_tag = TAG_Z1;
        mul_x     = {1'b0, a_reg[W-1:H]};
        mul_y     = {1'b0, b_reg[W-1:H]};
      end
      ISSUE2: begin
        issue_vld = 1'b1;
        issue_tag = TAG_Z2;
        mul_x     = sa;
        mul_y     = sb;
      end
      default: ;
    endcase
  end

  assign mul_prod = PW'(mul_x) * PW'(mul_y);

  logic [PW-1:0] pipe_data [MUL_LAT];
  logic          pipe_vld  [MUL_LAT];
  logic [1:0]    pipe_tag  [MUL_LAT];

  genvar gi;
  generate
    for (gi = 0; gi < MUL_LAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            pipe_vld[0]  <= 1'b0;
            pipe_tag[0]  <= TAG_Z0;
            pipe_data[0] <= '0;
          end else begin
            pipe_vld[0]  <= issue_vld;
            pipe_tag[0]  <= issue_tag;
            pipe_data[0] <= mul_prod;
          end
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            pipe_vld[gi]  <= 1'b0;
            pipe_tag[gi]  <= TAG_Z0;
            pipe_data[gi] <= '0;
          end else begin
            pipe_vld[gi]  <= pipe_vld[gi-1];
            pipe_tag[gi]  <= pipe_tag[gi-1];
            pipe_data[gi] <= pipe_data[gi-1];
          end
        end
      end
    end
  endgenerate

  logic          out_vld;
  logic [1:0]    out_tag;
  logic [PW-1:0] out_data;

  assign out_vld  = pipe_vld[MUL_LAT-1];
  assign out_tag  = pipe_tag[MUL_LAT-1];
  assign out_data = pipe_data[MUL_LAT-1];

  // z2_soon: the z2 result reaches the pipeline output in the next cycle, so COMBINE can use it live.
  logic z2_soon;
  generate
    if (MUL_LAT == 1) begin : g_soon_direct
      assign z2_soon = issue_vld && (issue_tag == TAG_Z2);
    end else begin : g_soon_pipe
      assign z2_soon = pipe_vld[MUL_LAT-2] && (pipe_tag[MUL_LAT-2] == TAG_Z2);
    end
  endgenerate

  // Summing modulo 2^(2W) gives the same bits as the 2W+2-bit sum truncated to 2W.
  logic [PW-1:0]  mid;
  logic [PW2-1:0] prod, result;

  assign mid    = out_data - z1_reg - z0_reg;
  assign prod   = (PW2'(z1_reg) << W) + (PW2'(mid) << H) + PW2'(z0_reg);
  assign result = neg_reg ? (~prod + PW2'(1)) : prod;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      busy      <= 1'b0;
      valid_out <= 1'b0;
      p         <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      neg_reg   <= 1'b0;
      z0_reg    <= '0;
      z1_reg    <= '0;
    end else begin
      valid_out <= 1'b0;
      if (out_vld && out_tag == TAG_Z0) z0_reg <= out_data;
      if (out_vld && out_tag == TAG_Z1) z1_reg <= out_data;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= a_mag;
            b_reg     <= b_mag;
            neg_reg   <= neg_in;
            busy      <= 1'b1;
            state_reg <= ISSUE0;
          end
        end
        ISSUE0:  state_reg <= ISSUE1;
        ISSUE1:  state_reg <= ISSUE2;
        ISSUE2:  state_reg <= z2_soon ? COMBINE : WAIT;
        WAIT:    if (z2_soon) state_reg <= COMBINE;
        COMBINE: begin
          p         <= result;
          valid_out <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_karatsuba_seq_mul.sv
// Directed bench for karatsuba_seq_mul at W=64, MUL_LAT=2 (signed vectors when KARATSUBA_SIGNED_EN is defined).
module tb_karatsuba_seq_mul;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [63:0]  a, b;
  logic         busy;
  logic [127:0] p;
  logic         valid_out;
`ifdef KARATSUBA_SIGNED_EN
  logic         signed_mode;
`endif

  int n_cmp;
  int n_fail;
  logic [127:0] last_p;

  karatsuba_seq_mul #(.W(64), .MUL_LAT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef KARATSUBA_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .busy      (busy),
    .p         (p),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start in the current cycle T; optionally pulse an extra start at T+ign_off.
  // Returns in cycle T+6 with start low, after checking the result there.
  task automatic do_op(input string tag, input logic [63:0] aa, input logic [63:0] bb,
                       input logic [127:0] exp, input int ign_off,
                       input logic [63:0] ia, input logic [63:0] ib);
    int nbusy, nearly, nhold;
    nbusy = 0; nearly = 0; nhold = 0;
    start = 1'b1; a = aa; b = bb;
    tick();
    for (int k = 1; k <= 5; k++) begin
      if (busy !== 1'b1) nbusy++;
      if (valid_out !== 1'b0) nearly++;
      if (p !== last_p) nhold++;
      start = (k == ign_off);
      a = (k == ign_off) ? ia : {$urandom, $urandom};
      b = (k == ign_off) ? ib : {$urandom, $urandom};
      tick();
    end
    start = 1'b0;
    check({tag, "_valid"}, valid_out, 1'b1);
    check({tag, "_busy_low"}, busy, 1'b0);
    check({tag, "_p"}, p, exp);
    check({tag, "_busy_window"}, nbusy, 0);
    check({tag, "_early_valid"}, nearly, 0);
    check({tag, "_p_held"}, nhold, 0);
    last_p = exp;
    $display("op %s: a=%h b=%h p=%h expected=%h", tag, aa, bb, p, exp);
  endtask

  task automatic idle_watch(input string tag, input int n);
    int nv;
    nv = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (valid_out !== 1'b0) nv++;
    end
    check({tag, "_no_valid"}, nv, 0);
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_p"}, p, last_p);
  endtask

  initial begin
    int nv;
    n_cmp = 0; n_fail = 0; last_p = '0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
`ifdef KARATSUBA_SIGNED_EN
    signed_mode = 1'b0;
`endif
    tick(); tick(); tick();
    check("reset_p", p, 128'd0);
    check("reset_busy", busy, 1'b0);
    check("reset_valid", valid_out, 1'b0);
    rst_n = 1'b1;
    tick();

    do_op("all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
          128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 0, '0, '0);
    tick();
    do_op("cross", 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000,
          128'h0000_0000_0000_0001_0000_0000_0000_0000, 0, '0, '0);
    tick();
    do_op("small", 64'd3, 64'd5, 128'd15, 0, '0, '0);
    tick();

    // Extra start at T+2 must be dropped, not queued.
    do_op("ignored", 64'd7, 64'd9, 128'd63, 2, 64'd2, 64'd2);
    idle_watch("ignored_after", 7);

    // Second start lands in the valid_out cycle.
    do_op("b2b_first", 64'd7, 64'd9, 128'd63, 0, '0, '0);
    do_op("b2b_second", 64'd10, 64'd10, 128'd100, 0, '0, '0);
    tick();

    // Reset asserted in T+3.
    start = 1'b1; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1234_5678_9ABC_DEF0;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    last_p = '0;
    check("midrst_p", p, 128'd0);
    check("midrst_busy", busy, 1'b0);
    nv = (valid_out !== 1'b0) ? 1 : 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (valid_out !== 1'b0) nv++;
    end
    check("midrst_no_valid", nv, 0);
    check("midrst_p_after", p, 128'd0);
    $display("op midrst: p=%h busy=%b valid_pulses=%0d", p, busy, nv);

    do_op("recover", 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0002,
          128'h0000_0000_0000_0000_0000_0001_FFFF_FFFE, 0, '0, '0);
    tick();

`ifdef KARATSUBA_SIGNED_EN
    signed_mode = 1'b1;
    do_op("s_neg1x2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
          128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 0, '0, '0);
    tick();
    do_op("s_minmin", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
          128'h4000_0000_0000_0000_0000_0000_0000_0000, 0, '0, '0);
    tick();
    do_op("s_pos", 64'd3, 64'd5, 128'd15, 0, '0, '0);
    tick();
    signed_mode = 1'b0;
    do_op("u_ones_x2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
          128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE, 0, '0, '0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
